sc_game_timer: RTL and testbench



---
 rtl/sc_game_timer.sv | 190 +++++++++++++++++++
 tb/tb_sc_game_timer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_game_timer.sv
// sc_game_timer: time base for the race-game state machine.
// Divides the system clock into base ticks and produces two one-cycle,
// active-low events:
//   - timer expiry at the end of a loadable countdown (timer units of SEC_DIV base ticks)
//   - car-move tick, every (2^SPEED_W - speed) base ticks
// Optional build macro: SC_GAME_TIMER_PAUSE_EN adds SC_GAME_TIMER_pause_InLow,
// which freezes all counters and the countdown FSM while low.
// Reset and clear are both synchronous, active low, and override every other input.
// SC_GAME_TIMER_dbgState_Out exposes the countdown FSM state (0 IDLE, 1 RUN, 2 EXPIRE).
module sc_game_timer #(
  parameter int PRESCALE_DIV = 50000,
  parameter int SEC_DIV      = 1000,
  parameter int TIMER_W      = 4,
  parameter int SPEED_W      = 4
) (
  input  logic               SC_GAME_TIMER_CLOCK_50,
  input  logic               SC_GAME_TIMER_RESET_InLow,
  input  logic               SC_GAME_TIMER_clear_InLow,
  input  logic               SC_GAME_TIMER_timerStart_InLow,
`ifdef SC_GAME_TIMER_PAUSE_EN
  input  logic               SC_GAME_TIMER_pause_InLow,
`endif
  input  logic [TIMER_W-1:0] SC_GAME_TIMER_timerLoad_In,
  input  logic [SPEED_W-1:0] SC_GAME_TIMER_speedCounter_In,
  output logic               SC_GAME_TIMER_timer_OutLow,
  output logic               SC_GAME_TIMER_speedComparator_OutLow,
  output logic [TIMER_W-1:0] SC_GAME_TIMER_remaining_Out,
  output logic               SC_GAME_TIMER_busy_Out,
  output logic [1:0]         SC_GAME_TIMER_dbgState_Out
);

  localparam int PRESC_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam int UNIT_W  = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE_DIV - 1);
  localparam logic [UNIT_W-1:0]  UNIT_MAX  = UNIT_W'(SEC_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_EXPIRE = 2'd2
  } state_t;

  // Registered state
  state_t               state_q,   state_d;
  logic [PRESC_W-1:0]   presc_q,   presc_d;
  logic [UNIT_W-1:0]    unit_q,    unit_d;
  logic [TIMER_W-1:0]   rem_q,     rem_d;
  logic [SPEED_W:0]     spd_cnt_q, spd_cnt_d;
  logic                 timer_n_q, timer_n_d;
  logic                 move_n_q,  move_n_d;
  logic                 busy_q,    busy_d;

  // Helpers
  logic                 run_en;
  logic                 base_tick;
  logic [SPEED_W:0]     spd_thresh;
  logic [SPEED_W:0]     spd_inc;
  logic                 speed_zero;

  // Counting enable: the pause input freezes everything except start/clear/reset.
`ifdef SC_GAME_TIMER_PAUSE_EN
  assign run_en = SC_GAME_TIMER_pause_InLow;
`else
  assign run_en = 1'b1;
`endif

  // Base tick on the last prescaler count; a paused prescaler holds at that
  // value, so a tick due on a pausing edge fires on the first running edge.
  assign base_tick  = run_en && (presc_q == PRESC_MAX);

  // Move threshold in base ticks; needs SPEED_W+1 bits because speed 0 would be 2^SPEED_W.
  assign spd_thresh = {1'b1, {SPEED_W{1'b0}}} - {1'b0, SC_GAME_TIMER_speedCounter_In};
  assign spd_inc    = spd_cnt_q + (SPEED_W+1)'(1);
  assign speed_zero = (SC_GAME_TIMER_speedCounter_In == '0);

  // Next-state logic for prescaler, countdown FSM, speed counter and pulses.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    unit_d    = unit_q;
    rem_d     = rem_q;
    spd_cnt_d = spd_cnt_q;
    timer_n_d = 1'b1;
    move_n_d  = 1'b1;

    // Prescaler free-runs 0..PRESCALE_DIV-1 while enabled.
    if (run_en) begin
      if (base_tick) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end

    // Move tick runs regardless of the countdown state. The >= compare lets a
    // lowered threshold fire on the very next base tick.
    if (speed_zero) begin
      spd_cnt_d = '0;
    end else if (base_tick) begin
      if (spd_inc >= spd_thresh) begin
        spd_cnt_d = '0;
        move_n_d  = 1'b0;
      end else begin
        spd_cnt_d = spd_inc;
      end
    end

    // Countdown FSM, frozen while paused.
    if (run_en) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (base_tick) begin
            if (unit_q == UNIT_MAX) begin
              unit_d = '0;
              if (rem_q != '0) begin
                rem_d = rem_q - TIMER_W'(1);
              end
              // The edge that takes remaining to zero is the expiry edge.
              if (rem_q <= TIMER_W'(1)) begin
                state_d   = ST_EXPIRE;
                timer_n_d = 1'b0;
              end
            end else begin
              unit_d = unit_q + UNIT_W'(1);
            end
          end
        end
        ST_EXPIRE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Start overrides the FSM from any state: reload, realign the time base
    // and drop any base tick that would have landed on this edge.
    if (!SC_GAME_TIMER_timerStart_InLow) begin
      rem_d     = SC_GAME_TIMER_timerLoad_In;
      presc_d   = '0;
      unit_d    = '0;
      spd_cnt_d = speed_zero ? '0 : spd_cnt_q;
      move_n_d  = 1'b1;
      if (SC_GAME_TIMER_timerLoad_In == '0) begin
        state_d   = ST_EXPIRE;
        timer_n_d = 1'b0;
      end else begin
        state_d   = ST_RUN;
        timer_n_d = 1'b1;
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  // State registers; reset and clear share the same synchronous effect.
  always_ff @(posedge SC_GAME_TIMER_CLOCK_50) begin
    if (!SC_GAME_TIMER_RESET_InLow || !SC_GAME_TIMER_clear_InLow) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      unit_q    <= '0;
      rem_q     <= '0;
      spd_cnt_q <= '0;
      timer_n_q <= 1'b1;
      move_n_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      unit_q    <= unit_d;
      rem_q     <= rem_d;
      spd_cnt_q <= spd_cnt_d;
      timer_n_q <= timer_n_d;
      move_n_q  <= move_n_d;
      busy_q    <= busy_d;
    end
  end

  assign SC_GAME_TIMER_timer_OutLow           = timer_n_q;
  assign SC_GAME_TIMER_speedComparator_OutLow = move_n_q;
  assign SC_GAME_TIMER_remaining_Out          = rem_q;
  assign SC_GAME_TIMER_busy_Out               = busy_q;
  assign SC_GAME_TIMER_dbgState_Out           = state_q;

endmodule

// File: tb/tb_sc_game_timer.sv
// tb_sc_game_timer: directed scenarios plus a randomized run of sc_game_timer,
// checked every cycle against a reference model built on elapsed-cycle arithmetic.
module tb_sc_game_timer;

  localparam int P    = 4;
  localparam int S    = 2;
  localparam int UNIT = P * S;
  localparam int TW   = 4;
  localparam int SW   = 4;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   = 1'b0;
  logic          clr_n   = 1'b1;
  logic          start_n = 1'b1;
  logic          pause_n = 1'b1;
  logic [TW-1:0] load    = '0;
  logic [SW-1:0] speed   = '0;

  logic          tmr_n, spd_n, busy;
  logic [TW-1:0] rem;
  logic [1:0]    dbg_state;

  sc_game_timer #(
    .PRESCALE_DIV(P), .SEC_DIV(S), .TIMER_W(TW), .SPEED_W(SW)
  ) dut (
    .SC_GAME_TIMER_CLOCK_50              (clk),
    .SC_GAME_TIMER_RESET_InLow           (rst_n),
    .SC_GAME_TIMER_clear_InLow           (clr_n),
    .SC_GAME_TIMER_timerStart_InLow      (start_n),
`ifdef SC_GAME_TIMER_PAUSE_EN
    .SC_GAME_TIMER_pause_InLow           (pause_n),
`endif
    .SC_GAME_TIMER_timerLoad_In          (load),
    .SC_GAME_TIMER_speedCounter_In       (speed),
    .SC_GAME_TIMER_timer_OutLow          (tmr_n),
    .SC_GAME_TIMER_speedComparator_OutLow(spd_n),
    .SC_GAME_TIMER_remaining_Out         (rem),
    .SC_GAME_TIMER_busy_Out              (busy),
    .SC_GAME_TIMER_dbgState_Out          (dbg_state)
  );

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  // Reference model: positions in time measured in clock edges
  int edge_n  = 0;   // index of the most recent active edge
  int m_zero  = 0;   // edge at which the base-tick grid was last aligned
  int m_start = 0;   // edge of the current countdown's start (shifted by pauses)
  int m_load  = 0;
  bit m_run   = 1'b0;
  int m_ticks = 0;   // base ticks since the last move pulse

  logic          exp_tmr  = 1'b1;
  logic          exp_spd  = 1'b1;
  logic          exp_busy = 1'b0;
  logic [TW-1:0] exp_rem  = '0;

  // Observation statistics used by the directed scenarios
  int tmr_cnt       = 0;
  int spd_cnt       = 0;
  int busy_cnt      = 0;
  int last_tmr_edge = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Apply the rules for one edge using the inputs present at that edge.
  task automatic model_update();
    int el;
    bit tick;
    edge_n++;
    exp_tmr = 1'b1;
    exp_spd = 1'b1;
    if (!rst_n || !clr_n) begin
      m_zero   = edge_n;
      m_run    = 1'b0;
      exp_rem  = '0;
      exp_busy = 1'b0;
      m_ticks  = 0;
    end else if (!start_n) begin
      m_zero = edge_n;
      if (speed == 0) m_ticks = 0;
      if (load == 0) begin
        m_run    = 1'b0;
        exp_rem  = '0;
        exp_busy = 1'b0;
        exp_tmr  = 1'b0;
      end else begin
        m_run    = 1'b1;
        m_start  = edge_n;
        m_load   = int'(load);
        exp_rem  = load;
        exp_busy = 1'b1;
      end
    end else if (!pause_n) begin
      // A paused edge simply does not count: shift every time reference by one.
      m_zero++;
      if (m_run) m_start++;
      if (speed == 0) m_ticks = 0;
    end else begin
      tick = ((edge_n - m_zero) % P) == 0;
      if (m_run) begin
        el = edge_n - m_start;
        if (el >= m_load * UNIT) begin
          m_run    = 1'b0;
          exp_rem  = '0;
          exp_busy = 1'b0;
          exp_tmr  = 1'b0;
        end else begin
          exp_rem  = TW'(m_load - el / UNIT);
          exp_busy = 1'b1;
        end
      end else begin
        exp_busy = 1'b0;
      end
      if (speed == 0) begin
        m_ticks = 0;
      end else if (tick) begin
        m_ticks++;
        if (m_ticks >= (1 << SW) - int'(speed)) begin
          exp_spd = 1'b0;
          m_ticks = 0;
        end
      end
    end
  endtask

  // Driver: one clock edge, model update, then compare all outputs 1 ns later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("timer_OutLow", 32'(tmr_n), 32'(exp_tmr));
    chk("speedComparator_OutLow", 32'(spd_n), 32'(exp_spd));
    chk("remaining_Out", 32'(rem), 32'(exp_rem));
    chk("busy_Out", 32'(busy), 32'(exp_busy));
    if (tmr_n === 1'b0) begin
      tmr_cnt++;
      last_tmr_edge = edge_n;
    end
    if (spd_n === 1'b0) spd_cnt++;
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_stats();
    tmr_cnt       = 0;
    spd_cnt       = 0;
    busy_cnt      = 0;
    last_tmr_edge = -1;
  endtask

  // Pulse start for one edge with the given load.
  task automatic do_start(input logic [TW-1:0] ld);
    load    = ld;
    start_n = 1'b0;
    step();
    start_n = 1'b1;
  endtask

  initial begin
    int start_e;

    // 1: reset for two edges, then idle at speed 0
    rst_n = 1'b0;
    steps(2);
    chk("reset_timer", 32'(tmr_n), 32'd1);
    chk("reset_move", 32'(spd_n), 32'd1);
    chk("reset_rem", 32'(rem), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    clear_stats();
    steps(40);
    chk("idle_move_pulses", 32'(spd_cnt), 32'd0);
    chk("idle_timer_pulses", 32'(tmr_cnt), 32'd0);

    // 2: load=3 countdown
    do_start(4'd3);
    start_e = edge_n;
    clear_stats();
    steps(8);
    chk("rem_after_8", 32'(rem), 32'd2);
    steps(8);
    chk("rem_after_16", 32'(rem), 32'd1);
    steps(14);
    chk("run3_busy_cycles", 32'(busy_cnt), 32'd23);
    chk("run3_expiries", 32'(tmr_cnt), 32'd1);
    chk("run3_expiry_offset", 32'(last_tmr_edge - start_e), 32'd24);

    // 3: load=0 expires immediately
    clear_stats();
    do_start(4'd0);
    chk("load0_pulse", 32'(tmr_n), 32'd0);
    steps(5);
    chk("load0_busy_cycles", 32'(busy_cnt), 32'd0);
    chk("load0_expiries", 32'(tmr_cnt), 32'd1);

    // 4: speed levels
    speed = 4'd15;
    steps(8);
    clear_stats();
    steps(40);
    chk("speed15_pulses", 32'(spd_cnt), 32'd10);
    speed = 4'd12;
    steps(16);
    clear_stats();
    steps(64);
    chk("speed12_pulses", 32'(spd_cnt), 32'd4);
    speed = 4'd0;
    clear_stats();
    steps(20);
    chk("speed0_pulses", 32'(spd_cnt), 32'd0);

    // 5: restart mid-run, then clear mid-run
    do_start(4'd3);
    steps(9);
    clear_stats();
    do_start(4'd3);
    start_e = edge_n;
    steps(30);
    chk("restart_expiries", 32'(tmr_cnt), 32'd1);
    chk("restart_expiry_offset", 32'(last_tmr_edge - start_e), 32'd24);
    do_start(4'd3);
    steps(10);
    clear_stats();
    clr_n = 1'b0;
    step();
    clr_n = 1'b1;
    chk("clear_rem", 32'(rem), 32'd0);
    steps(40);
    chk("clear_expiries", 32'(tmr_cnt), 32'd0);
    chk("clear_busy_cycles", 32'(busy_cnt), 32'd0);

`ifdef SC_GAME_TIMER_PAUSE_EN
    // 6: pause five edges during a load=1 run
    clear_stats();
    do_start(4'd1);
    start_e = edge_n;
    steps(2);
    pause_n = 1'b0;
    steps(5);
    pause_n = 1'b1;
    steps(10);
    chk("pause_expiry_offset", 32'(last_tmr_edge - start_e), 32'd13);
    chk("pause_expiries", 32'(tmr_cnt), 32'd1);
`endif

    // Randomized phase: random starts, loads, speed changes and rare clears
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) speed = SW'($urandom_range(0, 15));
      start_n = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
      load    = TW'($urandom_range(0, 4));
      clr_n   = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
`ifdef SC_GAME_TIMER_PAUSE_EN
      pause_n = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
`endif
      step();
    end
    start_n = 1'b1;
    clr_n   = 1'b1;
    pause_n = 1'b1;
    steps(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
